spi_ser_out: RTL

- Serial transmit half of the SPI byte link. Paired with the existing serial input shift register.
- Accepts a byte from the MSX bus write path and generates the bit clock `sclk_out`, which feeds the receiver's `serclk`.
- Shifts the byte out MSB-first on `ser_out`.
- Drives `shift_en`, which feeds the receiver's `enable`, so the receiver captures MISO on exactly 8 falling edges per transfer.
- Owns all transfer state: bit count, busy, completion and overrun.

---
 rtl/spi_ser_out.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/spi_ser_out.sv
// spi_ser_out -- transmit half of the SPI byte link.
//
// A falling edge on wr_n while idle loads data_in and launches one
// transfer: eight sclk_out periods (DIV cycles low, DIV cycles high),
// data MSB first on ser_out. The paired receiver samples on the falling
// edges of sclk_out; ser_out moves to the next bit one cycle after each
// falling edge so the receiver always sees a cycle of hold.
//
// Ports
//   reset      in   async, active-high; aborts any transfer
//   inv_serclk in   block clock (rising edge)
//   data_in    in   [7:0] byte to send, sampled on accept
//   wr_n       in   active-low write strobe (falling-edge detected)
//   ser_out    out  serial data (MOSI), idles high
//   sclk_out   out  bit clock to receiver, idles low
//   shift_en   out  receiver shift enable, high for the whole transfer
//   busy       out  transfer in progress
//   done       out  one-cycle completion pulse
//   overrun    out  sticky: write strobe seen while busy
module spi_ser_out #(
    parameter int DIV = 2
) (
    input  logic       reset,
    input  logic       inv_serclk,
    input  logic [7:0] data_in,
    input  logic       wr_n,
    output logic       ser_out,
    output logic       sclk_out,
    output logic       shift_en,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, FIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          ser_q, ser_d;
    logic          sclk_q, sclk_d;
    logic          shen_q, shen_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;
    logic          wr_prev_q;
    logic          wr_fall;

    assign wr_fall = wr_prev_q & ~wr_n;

    always_ff @(posedge inv_serclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            ser_q     <= 1'b1;
            sclk_q    <= 1'b0;
            shen_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            wr_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            ser_q     <= ser_d;
            sclk_q    <= sclk_d;
            shen_q    <= shen_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            wr_prev_q <= wr_n;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        data_d  = data_q;
        ser_d   = ser_q;
        sclk_d  = sclk_q;
        shen_d  = shen_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;

        // A strobe while anything is in flight (including the completion
        // cycle) is refused and flagged.
        if (wr_fall && state_q != IDLE)
            ovr_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (wr_fall) begin
                    data_d  = data_in;
                    ser_d   = data_in[7];
                    busy_d  = 1'b1;
                    shen_d  = 1'b1;
                    sclk_d  = 1'b0;
                    bit_d   = '0;
                    div_d   = '0;
                    ovr_d   = 1'b0;
                    state_d = LOW;
                end
            end
            LOW: begin
                // First cycle of every low phase after the first: the
                // receiver sampled on the previous edge, advance the bit.
                if (div_q == '0 && bit_q != '0) begin
                    ser_d  = data_q[6];
                    data_d = {data_q[6:0], 1'b0};
                end
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = HIGH;
                end else begin
                    div_d = div_q + CW'(1);
                end
            end
            HIGH: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        state_d = FIN;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        state_d = LOW;
                    end
                end else begin
                    div_d = div_q + CW'(1);
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                shen_d  = 1'b0;
                ser_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ser_out  = ser_q;
    assign sclk_out = sclk_q;
    assign shift_en = shen_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = ovr_q;

endmodule
